// File: rtl/trace_sched.sv
// trace_sched: run-controlled stimulus scheduler for formal property benches.
// Owns a 5-bit column index t and decodes four string-encoded lanes (A..D)
// from it, with start/hold/abort control, optional looping and a saturating
// loop-completion counter.
module trace_sched #(
   parameter int           TRACE_LEN = 32,
   parameter bit           LOOP      = 1'b0,
   parameter logic [255:0] trace_a   = {32{8'h5F}},
   parameter logic [255:0] trace_b   = {32{8'h5F}},
   parameter logic [255:0] trace_c   = {32{8'h5F}},
   parameter logic [255:0] trace_d   = {32{8'h5F}}
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       hold,
   input  logic       abort,
   output logic [4:0] t,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       busy,
   output logic       done,
   output logic [7:0] wraps,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [4:0] LAST = 5'(TRACE_LEN - 1);

   state_t     state_q, state_d;
   logic [4:0] t_q, t_d;
   logic [7:0] wraps_q, wraps_d;

   // Column 0 is the leftmost (most significant) character of the string.
   function automatic logic lane_bit(input logic [255:0] tr, input logic [4:0] col);
      int idx;
      idx = 8 * (31 - int'(col));
      return tr[idx +: 8] == 8'h2D;
   endfunction

   // State, column index and loop counter registers; reset clears all of them.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         t_q     <= 5'd0;
         wraps_q <= 8'd0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         wraps_q <= wraps_d;
      end
   end

   // Next-state logic: abort overrides everything; t only advances from RUN with hold low.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      wraps_d = wraps_q;
      if (abort) begin
         state_d = IDLE;
         t_d     = 5'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = RUN;
                  t_d     = 5'd0;
               end
            end
            RUN: begin
               if (hold) begin
                  state_d = HOLD;
               end else if (t_q != LAST) begin
                  t_d = t_q + 5'd1;
               end else if (LOOP) begin
                  t_d     = 5'd0;
                  wraps_d = (wraps_q == 8'hFF) ? wraps_q : wraps_q + 8'd1;
               end else begin
                  state_d = DONE;
               end
            end
            HOLD: begin
               // Release returns to RUN without advancing, so the held column lingers one cycle.
               if (!hold) state_d = RUN;
            end
            DONE: begin
               if (start) begin
                  state_d = RUN;
                  t_d     = 5'd0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output decode from registered state; lanes are quiet while idle.
   always_comb begin
      t     = t_q;
      state = state_q;
      wraps = wraps_q;
      busy  = (state_q == RUN) || (state_q == HOLD);
      done  = (state_q == DONE);
      A     = (state_q != IDLE) && lane_bit(trace_a, t_q);
      B     = (state_q != IDLE) && lane_bit(trace_b, t_q);
      C     = (state_q != IDLE) && lane_bit(trace_c, t_q);
      D     = (state_q != IDLE) && lane_bit(trace_d, t_q);
   end

endmodule
